// File: rtl/mul_unit_pkg.sv
// Shared constants and the stage-register layout for the pipelined MUL execute unit.
package mul_unit_pkg;

   localparam int WORD_SIZE  = 32;
   localparam int REG_BITS   = 5;
   localparam int MUL_STAGES = 5;

   localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
   localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
   localparam logic [6:0] MUL_FUNCT7     = 7'b0000001;
   localparam logic [2:0] MUL_FUNCT3     = 3'b000;

   typedef struct packed {
      logic                 valid;
      logic [REG_BITS-1:0]  rd;
      logic [WORD_SIZE-1:0] data;
   } mul_stage_t;

   function automatic logic is_mul_op(input logic       valid,
                                      input logic [6:0] opcode,
                                      input logic [6:0] funct7,
                                      input logic [2:0] funct3);
      return valid && (opcode == OPCODE_ALU) && (funct7 == MUL_FUNCT7)
             && (funct3 == MUL_FUNCT3);
   endfunction

endpackage

// File: rtl/mul_unit_stage_reg.sv
// One multiplier pipeline stage: reset clears it, flush drops the valid bit,
// stall holds it, otherwise it loads the upstream stage.
module mul_stage_reg
   import mul_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       flush,
   input  mul_stage_t stage_in,
   output mul_stage_t stage_out
);

   mul_stage_t stage_d;
   mul_stage_t stage_q;

   // Flush wins over stall so a frozen pipe can still be killed.
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d.valid = 1'b0;
      end else if (!stall) begin
         stage_d = stage_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_out = stage_q;

endmodule

// File: rtl/mul_unit.sv
// Fixed-latency MUL execute unit: product formed at entry, then carried down a
// stallable/flushable shift pipe whose last stage feeds writeback.
module mul_unit
   import mul_unit_pkg::mul_stage_t;
   import mul_unit_pkg::is_mul_op;
#(
   parameter int WORD_SIZE  = mul_unit_pkg::WORD_SIZE,
   parameter int MUL_STAGES = mul_unit_pkg::MUL_STAGES,
   parameter int REG_BITS   = mul_unit_pkg::REG_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic [6:0]           opcode,
   input  logic [6:0]           funct7,
   input  logic [2:0]           funct3,
   input  logic [WORD_SIZE-1:0] s1,
   input  logic [WORD_SIZE-1:0] s2,
   input  logic [REG_BITS-1:0]  rd,
   input  logic                 stall_in,
   input  logic                 flush,
   input  logic [REG_BITS-1:0]  rd_query,
   output logic                 stall_out,
   output logic                 rd_hit,
   output logic                 valid_out,
   output logic [REG_BITS-1:0]  rd_out,
   output logic [WORD_SIZE-1:0] result
);

   logic                 is_mul;
   logic [WORD_SIZE-1:0] product;
   mul_stage_t           pipe [MUL_STAGES+1];

   assign is_mul  = is_mul_op(valid_in, opcode, funct7, funct3);
   // Low half of the product is sign-agnostic, so one unsigned multiply serves both.
   assign product = s1 * s2;

   assign pipe[0] = '{valid: is_mul, rd: rd, data: product};

   for (genvar k = 1; k <= MUL_STAGES; k++) begin : g_stage
      mul_stage_reg u_stage (
         .clk       (clk),
         .reset     (reset),
         .stall     (stall_in),
         .flush     (flush),
         .stage_in  (pipe[k-1]),
         .stage_out (pipe[k])
      );
   end

   assign stall_out = is_mul & stall_in;
   assign valid_out = pipe[MUL_STAGES].valid;
   assign rd_out    = pipe[MUL_STAGES].rd;
   assign result    = pipe[MUL_STAGES].data;

   always_comb begin
      rd_hit = 1'b0;
      for (int k = 1; k <= MUL_STAGES; k++) begin
         if (pipe[k].valid && (pipe[k].rd == rd_query)) begin
            rd_hit = 1'b1;
         end
      end
      if (rd_query == '0) begin
         rd_hit = 1'b0;
      end
   end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Execute-side consumer of the decode/execute pipeline register: takes the registered instruction fields (valid, opcode, funct7, funct3, s1, s2, rd) and runs MUL instructions through a fixed-latency pipelined multiplier.
- Drives the back-pressure stall that the decode/execute register consumes.
- Provides an in-flight destination query for the hazard logic.
- Delivers results to writeback with a valid/rd tag.

Parameters:
- WORD_SIZE, 32, operand/result width
- MUL_STAGES, 5, pipeline depth (latency in cycles), legal range 2..8
- REG_BITS, 5, register index width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  decode/execute register holds a valid instruction
- opcode  input  7  instruction opcode
- funct7  input  7  funct7 field
- funct3  input  3  funct3 field
- s1  input  WORD_SIZE  source operand 1
- s2  input  WORD_SIZE  source operand 2
- rd  input  REG_BITS  destination register
- stall_in  input  1  writeback cannot accept; freeze all stages
- flush  input  1  kill all in-flight and incoming MULs (branch mispredict/exception)
- rd_query  input  REG_BITS  register index from the hazard unit
- stall_out  output  1  to the decode/execute register: hold current contents
- rd_hit  output  1  some valid in-flight stage targets rd_query
- valid_out  output  1  result valid this cycle
- rd_out  output  REG_BITS  destination of result
- result  output  WORD_SIZE  low WORD_SIZE bits of s1*s2

Behaviour:
- Request: is_mul = valid_in & opcode==OPCODE_ALU & funct7==MUL_FUNCT7 & funct3==MUL_FUNCT3 (000).
  - Non-MUL instructions are ignored entirely.
- Stage registers 1..MUL_STAGES, each holding {valid, rd, partial/final product}.
  - Output ports are driven from stage MUL_STAGES.
- Accept: at a rising edge with is_mul & !stall_in & !flush & !reset, stage 1 loads valid=1, rd, and operands/product.
  - Otherwise stage 1 loads valid=0 when not stalled.
- Advance: with !stall_in, every stage k shifts into k+1 each edge.
  - The last stage's contents are overwritten, i.e. consumed by writeback.
- Latency: accepted at edge E with no stalls -> valid_out=1 in the cycle following edge E+MUL_STAGES-1, for exactly one cycle.
  - Back-to-back accepts give one result per cycle, in order.
- Product: low WORD_SIZE bits of s1*s2. Signed and unsigned are identical for the low half, so no sign handling.
  - Internal split across stages is free; only the final value and latency are specified.
- stall_in=1: all stages hold, including valid bits.
  - valid_out, rd_out and result stay stable and are reasserted until stall_in drops.
- stall_out = is_mul & stall_in (combinational).
  - The decode/execute register holds, so the MUL is presented again next cycle and accepted once stall_in clears.
  - No MUL is lost or duplicated.
- flush=1: at the edge, all stage valid bits clear, including the incoming MUL.
  - Flush beats stall_in.
  - Data fields are don't-care once valid=0.
- rd_hit (combinational) = OR over stages of (valid & rd==rd_query), forced 0 when rd_query==0.
  - The incoming stage-0 request is not included.
- rd==0 MULs still flow through the pipe with valid_out=1; writeback discards them.
- Reset: at the edge, all valid bits clear, so valid_out=0, rd_out=0, result=0 and rd_hit=0 in the next cycle.
  - reset has priority over flush, stall_in and accept.
  - Reset mid-operation drops all in-flight MULs.
- X-free: valid bits are never X after reset; data fields may hold stale values only when valid=0.

Decomposition:
- Shared package/defines (existing): WORD_SIZE, OPCODE_ALU, MUL_FUNCT7, MUL_FUNCT3.
  - Add REG_BITS and a default MUL_STAGES define.
- Package typedef mul_stage_t: packed {valid, rd, data}.
- One natural sub-module: mul_stage_reg, a single stage register with stall/flush/reset priority, instantiated MUL_STAGES times via generate.
- The multiply datapath stays in mul_unit.

Test Plan:
- Single MUL: s1=23, s2=7, rd=5, no stalls -> valid_out=1 exactly 5 cycles after accept with result=161, rd_out=5; valid_out=0 before and after.
- Back-to-back: 3 consecutive MULs (3*4 rd1, -2*6 rd2, 0xFFFFFFFF*0xFFFFFFFF rd3) -> results 12, 0xFFFFFFF4, 1 on consecutive cycles, in order.
- Stall: MUL 212*73 rd=9 in flight; stall_in=1 for 3 cycles at stage 3 -> outputs frozen, valid_out appears 3 cycles late with result=15476.
  - A new MUL presented during the stall sees stall_out=1 and is accepted only after release, exactly once.
- Flush: two MULs in flight plus one incoming, flush=1 for one cycle -> no valid_out for any of them; a MUL issued the next cycle completes normally.
- Hazard: MUL rd=7 in flight, rd_query=7 -> rd_hit=1 until the cycle after the result leaves.
  - rd_query=0 or 8 -> rd_hit=0.
- Reset mid-flight: reset=1 at cycle 2 of a MUL -> valid_out=0, rd_out=0, result=0, rd_hit=0 the next cycle; the dropped MUL never emerges.
  - Non-MUL (OPCODE_ALU_IMM, valid_in=1) -> never accepted, stall_out=0.
